// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU memory-bus controller: one fixed-latency RAM transaction per command.
// Optional switch/LED registers are decoded when MEM_MMIO_EN is defined.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_dout
`ifdef MEM_MMIO_EN
  ,
  input  logic [7:0]        sw,
  output logic [7:0]        led
`endif
);

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sw_hit, led_hit;

`ifdef MEM_MMIO_EN
  localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'('h140);
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'('h100);

  logic [7:0] led_q, led_d;

  // MMIO hits bypass the RAM strobes entirely; latency is unchanged.
  assign sw_hit  = !wr_q && (addr_q == SW_ADDR);
  assign led_hit =  wr_q && (addr_q == LED_ADDR);
  assign led     = led_q;
`else
  assign sw_hit  = 1'b0;
  assign led_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_MMIO_EN
      led_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
`ifdef MEM_MMIO_EN
      led_q   <= led_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
`ifdef MEM_MMIO_EN
    led_d     = led_q;
`endif
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    mem_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
          addr_d  = mem_addr;
          din_d   = write_data;
          wr_d    = (mem_cmd == MWRITE);
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_re = !wr_q && !sw_hit;
        ram_we = wr_q && (cnt_q == 4'd0) && !led_hit;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!wr_q) begin
`ifdef MEM_MMIO_EN
            rdata_d = sw_hit ? {{(DATA_W-8){1'b0}}, sw} : ram_dout;
`else
            rdata_d = ram_dout;
`endif
          end
`ifdef MEM_MMIO_EN
          if (led_hit) led_d = din_q[7:0];
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_busy  = (state_q != IDLE);
  assign read_data = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized bench for mem_bus_ctrl against a transaction-level memory model.
module tb_mem_bus_ctrl;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_busy, mem_ready;
  logic [8:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        ram_we, ram_re;
`ifdef MEM_MMIO_EN
  logic [7:0]  sw, led;
  logic [7:0]  exp_led;
`endif

  logic [15:0] tb_mem  [512];
  logic [15:0] ref_mem [512];
  logic [15:0] last_rd;
  int          we_total;
  int          n_cmp, n_mis;

  mem_bus_ctrl #(.ADDR_W(9), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .mem_busy(mem_busy),
    .mem_ready(mem_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_re(ram_re), .ram_dout(ram_dout)
`ifdef MEM_MMIO_EN
    , .sw(sw), .led(led)
`endif
  );

  always #5 clk = ~clk;

  assign ram_dout = tb_mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      tb_mem[ram_addr] <= ram_din;
      we_total <= we_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left just after a rising edge with the controller idle.
  task automatic do_txn(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    logic is_rd, is_wr, mm_rd, mm_wr;
    logic [15:0] exp_rd;
    int we0;
    is_rd = (cmd == 2'b01);
    is_wr = (cmd == 2'b10);
    mm_rd = 1'b0;
    mm_wr = 1'b0;
`ifdef MEM_MMIO_EN
    mm_rd = is_rd && (addr == 9'h140);
    mm_wr = is_wr && (addr == 9'h100);
`endif
    mem_cmd = cmd; mem_addr = addr; write_data = data;
    we0 = we_total;
    if (!is_rd && !is_wr) begin
      repeat (2) begin
        @(negedge clk);
        chk("idle_busy", mem_busy, 0);
        chk("idle_re", ram_re, 0);
        @(posedge clk); #1;
      end
      chk("idle_no_we", we_total - we0, 0);
      mem_cmd = 2'b00;
    end else begin
      @(posedge clk); #1;
      mem_cmd = 2'($urandom); mem_addr = 9'($urandom); write_data = 16'($urandom);
      for (int i = 1; i <= W + 1; i++) begin
        @(negedge clk);
        chk("acc_busy", mem_busy, 1);
        chk("acc_ready", mem_ready, 0);
        chk("acc_addr", ram_addr, addr);
        if (is_wr) chk("acc_din", ram_din, data);
        chk("acc_re", ram_re, is_rd && !mm_rd);
        chk("acc_we", ram_we, is_wr && !mm_wr && (i == W + 1));
        @(posedge clk); #1;
      end
      mem_cmd = 2'b00;
      if (is_rd) begin
        exp_rd = ref_mem[addr];
`ifdef MEM_MMIO_EN
        if (mm_rd) exp_rd = {8'h00, sw};
`endif
        last_rd = exp_rd;
      end
      if (is_wr && !mm_wr) ref_mem[addr] = data;
`ifdef MEM_MMIO_EN
      if (mm_wr) exp_led = data[7:0];
`endif
      @(negedge clk);
      chk("done_ready", mem_ready, 1);
      chk("done_busy", mem_busy, 1);
      chk("done_rdata", read_data, last_rd);
      chk("we_count", we_total - we0, (is_wr && !mm_wr) ? 1 : 0);
`ifdef MEM_MMIO_EN
      chk("led", led, exp_led);
`endif
      @(posedge clk); #1;
      chk("post_busy", mem_busy, 0);
      chk("post_ready", mem_ready, 0);
    end
  endtask

  initial begin
    int nrdy, first_k, second_k, we0;
    logic [15:0] old;
    reset = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0;
    last_rd = '0;
`ifdef MEM_MMIO_EN
    sw = 8'h00; exp_led = 8'h00;
`endif
    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;

    #2 reset = 1'b1;
    #1;
    chk("rst_busy", mem_busy, 0);
    chk("rst_ready", mem_ready, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
`ifdef MEM_MMIO_EN
    chk("rst_led", led, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    do_txn(2'b01, 9'h005, 16'h0000);
    do_txn(2'b10, 9'h010, 16'h1234);
    do_txn(2'b01, 9'h010, 16'h0000);
    chk("rd_1234", read_data, 16'h1234);

    // Held MREAD: second transaction picks up the address present in the next IDLE.
    mem_cmd = 2'b01; mem_addr = 9'h020;
    nrdy = 0; first_k = 0; second_k = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1) mem_addr = 9'h021;
      @(negedge clk);
      if (k == 2) chk("held_addr", ram_addr, 9'h020);
      if (mem_ready) begin
        nrdy++;
        if (nrdy == 1) first_k = k; else second_k = k;
      end
      if (k == 4) chk("held_rd1", read_data, ref_mem[9'h020]);
      if (k == 9) begin
        chk("held_rd2", read_data, ref_mem[9'h021]);
        mem_cmd = 2'b00;
      end
    end
    chk("held_pulses", nrdy, 2);
    chk("held_first", first_k, W + 2);
    chk("held_spacing", second_k - first_k, W + 3);
    last_rd = ref_mem[9'h021];
    @(posedge clk); #1;

    // Reset during the 2nd ACCESS cycle of a write must suppress the strobe.
    old = ref_mem[9'h055];
    we0 = we_total;
    mem_cmd = 2'b10; mem_addr = 9'h055; write_data = ~old;
    @(posedge clk); #1;
    mem_cmd = 2'b00;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_busy", mem_busy, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_rdata", read_data, 0);
    chk("abort_addr", ram_addr, 0);
    repeat (3) @(posedge clk);
    chk("abort_no_we", we_total - we0, 0);
    #1 reset = 1'b0;
    last_rd = '0;
`ifdef MEM_MMIO_EN
    exp_led = 8'h00;
`endif
    do_txn(2'b01, 9'h055, 16'h0000);
    chk("abort_mem", read_data, old);

`ifdef MEM_MMIO_EN
    do_txn(2'b10, 9'h100, 16'h00A5);
    chk("led_a5", led, 8'hA5);
    sw = 8'h3C;
    do_txn(2'b01, 9'h140, 16'h0000);
    chk("sw_3c", read_data, 16'h003C);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [8:0] a;
      a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
`ifdef MEM_MMIO_EN
      sw = 8'($urandom);
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 9'h100 : 9'h140;
`endif
      do_txn(2'($urandom_range(0, 3)), a, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
